// File: rtl/alu_multiciclo_pkg.sv
// Shared ALU definitions: opcode constants and FSM state encoding.
// The control unit imports this package too.
package alu_defs;

   localparam int OPW = 4;

   localparam logic [OPW-1:0] OP_AND   = 4'b0000;
   localparam logic [OPW-1:0] OP_OR    = 4'b0001;
   localparam logic [OPW-1:0] OP_ADD   = 4'b0010;
   localparam logic [OPW-1:0] OP_SUB   = 4'b0110;
   localparam logic [OPW-1:0] OP_SLT   = 4'b0111;
   localparam logic [OPW-1:0] OP_NOR   = 4'b1100;
   localparam logic [OPW-1:0] OP_MULTU = 4'b1000;
   localparam logic [OPW-1:0] OP_DIVU  = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } estado_t;

endpackage

// File: rtl/muldiv_iterativo.sv
// Shared SIZEDATA-step datapath: right shift-add multiply (modo=0) or
// restoring divide (modo=1). Exposes the next-step values so the last step
// can be captured straight into the output registers.
module muldiv_iterativo #(
   parameter int SIZEDATA = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                carga_i,
   input  logic                paso_i,
   input  logic                modo_i,
   input  logic [SIZEDATA-1:0] a_i,
   input  logic [SIZEDATA-1:0] b_i,
   output logic [SIZEDATA-1:0] hi_d_o,
   output logic [SIZEDATA-1:0] lo_d_o,
   output logic                ultimo_o
);

   localparam int CW = $clog2(SIZEDATA) + 1;

   logic [SIZEDATA-1:0] acc_q, sh_q, b_q;
   logic                modo_q;
   logic [CW-1:0]       cnt_q;

   logic [SIZEDATA:0]   suma, resto, dif;
   logic                cabe;

   always_comb begin
      suma   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
      resto  = {acc_q, sh_q[SIZEDATA-1]};
      dif    = resto - {1'b0, b_q};
      // Magnitude compare instead of the borrow bit: with b=0 the partial
      // remainder can exceed 2^SIZEDATA and must still "fit".
      cabe   = (resto >= {1'b0, b_q});
      hi_d_o = suma[SIZEDATA:1];
      lo_d_o = {suma[0], sh_q[SIZEDATA-1:1]};
      if (modo_q) begin
         hi_d_o = cabe ? dif[SIZEDATA-1:0] : resto[SIZEDATA-1:0];
         lo_d_o = {sh_q[SIZEDATA-2:0], cabe};
      end
   end

   assign ultimo_o = (cnt_q == CW'(SIZEDATA - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         sh_q   <= '0;
         b_q    <= '0;
         modo_q <= 1'b0;
         cnt_q  <= '0;
      end else if (carga_i) begin
         acc_q  <= '0;
         sh_q   <= a_i;
         b_q    <= b_i;
         modo_q <= modo_i;
         cnt_q  <= '0;
      end else if (paso_i) begin
         acc_q  <= hi_d_o;
         sh_q   <= lo_d_o;
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative
// MULTU/DIVU with HI/LO results and an inicio/busy/done handshake.
module alu_multiciclo
   import alu_defs::*;
#(
   parameter int SIZEDATA = 32,
   parameter int OP       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inicio,
   input  logic [SIZEDATA-1:0] a,
   input  logic [SIZEDATA-1:0] b,
   input  logic [OP-1:0]       operador,
   output logic                busy,
   output logic                done,
   output logic [SIZEDATA-1:0] resultado,
   output logic [SIZEDATA-1:0] hi,
   output logic                zero,
   output logic                overflow,
   output logic                div0
);

   localparam int M = SIZEDATA - 1;

   estado_t             estado_q;
   logic                busy_q, done_q, zero_q, ovf_q, div0_q, div0_pend_q;
   logic [SIZEDATA-1:0] res_q, hi_q;

   logic                es_mul, es_div, acepta;
   logic [SIZEDATA-1:0] suma, resta, alu_res_d;
   logic                alu_ovf_d;
   logic [SIZEDATA-1:0] md_hi, md_lo;
   logic                md_ultimo;

   assign es_mul = (operador == OP'(OP_MULTU));
   assign es_div = (operador == OP'(OP_DIVU));
   assign acepta = (estado_q == IDLE) && inicio;

   always_comb begin
      suma      = a + b;
      resta     = a - b;
      alu_res_d = '0;
      alu_ovf_d = 1'b0;
      case (operador)
         OP'(OP_AND): alu_res_d = a & b;
         OP'(OP_OR):  alu_res_d = a | b;
         OP'(OP_NOR): alu_res_d = ~(a | b);
         OP'(OP_SLT): alu_res_d = SIZEDATA'($signed(a) < $signed(b));
         OP'(OP_ADD): begin
            alu_res_d = suma;
            alu_ovf_d = (a[M] == b[M]) && (suma[M] != a[M]);
         end
         OP'(OP_SUB): begin
            alu_res_d = resta;
            alu_ovf_d = (a[M] != b[M]) && (resta[M] != a[M]);
         end
         default: ;
      endcase
   end

   muldiv_iterativo #(.SIZEDATA(SIZEDATA)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .carga_i (acepta && (es_mul || es_div)),
      .paso_i  (estado_q == CALC),
      .modo_i  (es_div),
      .a_i     (a),
      .b_i     (b),
      .hi_d_o  (md_hi),
      .lo_d_o  (md_lo),
      .ultimo_o(md_ultimo)
   );

   // Single-cycle ops are computed on the accept edge so done lands in FIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_q       <= '0;
         hi_q        <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         div0_q      <= 1'b0;
         div0_pend_q <= 1'b0;
      end else begin
         case (estado_q)
            IDLE: begin
               done_q <= 1'b0;
               if (inicio) begin
                  busy_q      <= 1'b1;
                  div0_pend_q <= es_div && (b == '0);
                  if (es_mul || es_div) begin
                     estado_q <= CALC;
                  end else begin
                     estado_q <= FIN;
                     done_q   <= 1'b1;
                     res_q    <= alu_res_d;
                     hi_q     <= '0;
                     zero_q   <= (alu_res_d == '0);
                     ovf_q    <= alu_ovf_d;
                     div0_q   <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (md_ultimo) begin
                  estado_q <= FIN;
                  done_q   <= 1'b1;
                  res_q    <= md_lo;
                  hi_q     <= md_hi;
                  zero_q   <= (md_lo == '0);
                  ovf_q    <= 1'b0;
                  div0_q   <= div0_pend_q;
               end
            end
            FIN: begin
               estado_q <= IDLE;
               done_q   <= 1'b0;
               busy_q   <= 1'b0;
            end
            default: estado_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign resultado = res_q;
   assign hi        = hi_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign div0      = div0_q;

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU in the MIPS32 core.
- Keeps the single-cycle op set (AND, OR, ADD, SUB, SLT, NOR) but registers every result.
- Adds iterative unsigned multiply and divide with HI/LO results, status flags, and a start/busy/done handshake.
- Sits in the EX stage. The control unit stalls the pipeline while busy is high.

Parameters:
- SIZEDATA, 32, operand and result width in bits (legal values: 8 to 64).
- OP, 4, width of the operador code.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inicio  in  1  start request; sampled only when busy=0.
- a  in  SIZEDATA  operand A; captured on accept.
- b  in  SIZEDATA  operand B; captured on accept.
- operador  in  OP  operation code; captured on accept.
- busy  out  1  high from the cycle after accept until the cycle done is asserted, inclusive.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
- resultado  out  SIZEDATA  LO result (product low half, quotient, or plain result).
- hi  out  SIZEDATA  HI result (product high half, or remainder); 0 for non-muldiv ops.
- zero  out  1  resultado == 0, valid for every op.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- div0  out  1  DIVU executed with b == 0.

Behaviour:
- Reset: asserted asynchronously, whatever the state. Forces state IDLE; busy, done, zero, overflow and div0 to 0; resultado and hi to 0. Any in-flight operation is discarded.
- Opcodes (shared package):
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^SIZEDATA)
  - 0110 SUB
  - 0111 SLT (signed compare; result 1 or 0)
  - 1100 NOR (bitwise ~(a|b))
  - 1000 MULTU
  - 1001 DIVU
  - any other code: resultado=0, hi=0, zero=1, normal 1-cycle completion.
- State machine: IDLE, CALC, FIN.
  - IDLE: accepts when inicio=1. Latches a, b and operador.
    - Non-muldiv op goes to FIN, so done is asserted 1 cycle after accept.
    - MULTU/DIVU goes to CALC with iteration counter = 0.
  - CALC: performs one shift-add (MULTU) or one restoring subtract-shift (DIVU) step per cycle. Leaves for FIN after exactly SIZEDATA steps, so done is asserted SIZEDATA+1 cycles after accept.
  - FIN: done=1 and output registers updated for one cycle, then IDLE.
  - inicio in FIN or CALC is ignored. A new accept is possible in the cycle after done. Back-to-back throughput is one op per 2 cycles minimum.
- Busy: busy=1 in CALC and FIN; busy=0 in IDLE.
- Output hold: resultado, hi and flags hold their last values until the next done. They do not change during CALC.
- MULTU: {hi,resultado} = a*b as a full 2*SIZEDATA unsigned product.
- DIVU:
  - b != 0: resultado = a/b, hi = a%b, unsigned.
  - b == 0: resultado = all ones, hi = a, div0 = 1. The op still takes SIZEDATA+1 cycles, so latency is constant.
  - div0 is cleared by the next completed op.
- Overflow: ADD sets it when sign(a)==sign(b) and sign(sum) != sign(a). SUB sets it when sign(a) != sign(b) and sign(diff) != sign(a).
- Operand stability: operand changes after accept have no effect.

Decomposition:
- Package alu_defs holds the OP-wide opcode constants (OP_AND … OP_DIVU) and the state encoding (IDLE/CALC/FIN). It is shared with the control unit.
- One sub-module, muldiv_iterativo, holds the shared SIZEDATA-cycle shift datapath (accumulator, shift register, counter) plus a modo select.
- The top level holds the FSM, the single-cycle ops and the output/flag registers.

Test Plan:
- Reset during MULTU at CALC step 10 (a=7, b=9) -> outputs all 0 and busy=0 immediately, asynchronously. After release, a new ADD completes normally.
- ADD a=0x7FFFFFFF, b=1 -> done 1 cycle after accept, resultado=0x80000000, overflow=1, zero=0, hi=0. SUB a=5, b=5 -> resultado=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFF (-1), b=1 -> resultado=1. NOR a=0xF0F0F0F0, b=0x0F0F0F00 -> resultado=0x0000000F.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 cycles after accept, hi=0xFFFFFFFE, resultado=0x00000001, busy high for 33 cycles.
- DIVU a=100, b=7 -> resultado=14, hi=2, div0=0. DIVU a=0x1234, b=0 -> resultado=0xFFFFFFFF, hi=0x1234, div0=1, latency 33 cycles.
- inicio held high with operand changes throughout a DIVU -> only one accept occurs and the result matches the latched operands. Next accept occurs in the cycle after the done pulse.
